// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Wait-state counter: up to 15 extra ACCESS cycles per region.
  localparam int WS_W = 4;
  typedef logic [WS_W-1:0] ws_t;

  // Region codes taken from addr[13:11]; codes 3..7 are unmapped.
  localparam logic [2:0] REG_ROM = 3'd0;
  localparam logic [2:0] REG_RAM = 3'd1;
  localparam logic [2:0] REG_OUT = 3'd2;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles both master request ports and the shared slave bus.
// Latency: n/a (wires only).
// Backpressure: req is held by a master until its one-cycle ready pulse.
// Modports:
//   master - the arbiter side: owns the slave bus and the mN_rdata/ready/err returns
//   slave  - the environment side: the two requesters plus the slave read data
interface mem_bus_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        m1_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_re;
  logic        mem_we;
  logic        nce_rom;
  logic        nce_ram;
  logic        nce_out;
  logic        grant;

  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_rdata, m0_ready, m0_err,
    output m1_rdata, m1_ready, m1_err,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output nce_rom, nce_ram, nce_out, grant
  );

  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_rdata, m0_ready, m0_err,
    input  m1_rdata, m1_ready, m1_err,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  nce_rom, nce_ram, nce_out, grant
  );

endinterface

// File: rtl/mem_region_decode.sv
// Region decoder: addr[13:11] -> active-low chip enables, wait states, unmapped flag.
// Latency: combinational.
// Backpressure: none.
// Ports: region (addr[13:11]) in; nce_rom/nce_ram/nce_out, ws, unmapped out.
module mem_region_decode
  import mem_bus_pkg::*;
#(
  parameter int ROM_WS = 0,
  parameter int RAM_WS = 1,
  parameter int OUT_WS = 0
) (
  input  logic [2:0] region,
  output logic       nce_rom,
  output logic       nce_ram,
  output logic       nce_out,
  output ws_t        ws,
  output logic       unmapped
);

  always_comb begin
    nce_rom  = 1'b1;
    nce_ram  = 1'b1;
    nce_out  = 1'b1;
    ws       = '0;
    unmapped = 1'b0;
    case (region)
      REG_ROM: begin
        nce_rom = 1'b0;
        ws      = ws_t'(ROM_WS);
      end
      REG_RAM: begin
        nce_ram = 1'b0;
        ws      = ws_t'(RAM_WS);
      end
      REG_OUT: begin
        nce_out = 1'b0;
        ws      = ws_t'(OUT_WS);
      end
      // Unmapped: no enable, single ACCESS cycle.
      default: unmapped = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared ROM/RAM/output bus (m0 = CPU, m1 = loader).
// Latency: req seen at edge T -> mN_ready in cycle T+2+WS; one transaction per 3+WS cycles.
// Backpressure: a master holds req until its ready pulse; losers simply wait in IDLE.
// Ports: clk, rst (sync, active-high); bus (mem_bus_arbiter_if.master) carries both
//   master request/response groups and the shared slave bus.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on simultaneous requests;
//   undefined gives fixed priority with m0 always winning.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ROM_WS = 0,
  parameter int RAM_WS = 1,
  parameter int OUT_WS = 0
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.master  bus
);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic        unmapped_q, unmapped_d;
  ws_t         cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        re_q, re_d;
  logic        wr_q, wr_d;
  logic        nce_rom_q, nce_rom_d;
  logic        nce_ram_q, nce_ram_d;
  logic        nce_out_q, nce_out_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        ready0_q, ready0_d;
  logic        ready1_q, ready1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        dec_nce_rom, dec_nce_ram, dec_nce_out, dec_unmapped;
  ws_t         dec_ws;

  // Winner selection; only meaningful when at least one req is high.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    sel = (bus.m0_req && bus.m1_req) ? ~grant_q : bus.m1_req;
`else
    sel = ~bus.m0_req;
`endif
    sel_we    = sel ? bus.m1_we    : bus.m0_we;
    sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
  end

  mem_region_decode #(
    .ROM_WS (ROM_WS),
    .RAM_WS (RAM_WS),
    .OUT_WS (OUT_WS)
  ) u_decode (
    .region   (sel_addr[13:11]),
    .nce_rom  (dec_nce_rom),
    .nce_ram  (dec_nce_ram),
    .nce_out  (dec_nce_out),
    .ws       (dec_ws),
    .unmapped (dec_unmapped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      unmapped_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      re_q       <= 1'b0;
      wr_q       <= 1'b0;
      nce_rom_q  <= 1'b1;
      nce_ram_q  <= 1'b1;
      nce_out_q  <= 1'b1;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ready0_q   <= 1'b0;
      ready1_q   <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      unmapped_q <= unmapped_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      wr_q       <= wr_d;
      nce_rom_q  <= nce_rom_d;
      nce_ram_q  <= nce_ram_d;
      nce_out_q  <= nce_out_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      ready0_q   <= ready0_d;
      ready1_q   <= ready1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  // Next-state and next-output logic; every bus output is a register, so the
  // values computed here appear on the bus one cycle later.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    unmapped_d = unmapped_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    re_d       = 1'b0;
    wr_d       = 1'b0;
    nce_rom_d  = 1'b1;
    nce_ram_d  = 1'b1;
    nce_out_d  = 1'b1;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ready0_d   = 1'b0;
    ready1_d   = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d    = ACCESS;
          grant_d    = sel;
          we_d       = sel_we;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          unmapped_d = dec_unmapped;
          cnt_d      = dec_ws;
          nce_rom_d  = dec_nce_rom;
          nce_ram_d  = dec_nce_ram;
          nce_out_d  = dec_nce_out;
          re_d       = !sel_we && !dec_unmapped;
          // With zero wait states the first ACCESS cycle is also the last.
          wr_d       = sel_we && !dec_unmapped && (dec_ws == '0);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          // Writes (mapped or not) leave the master's read data untouched.
          if (grant_q) begin
            ready1_d = 1'b1;
            err1_d   = unmapped_q;
            if (!we_q) rdata1_d = unmapped_q ? UNMAPPED_RDATA : bus.mem_rdata;
          end else begin
            ready0_d = 1'b1;
            err0_d   = unmapped_q;
            if (!we_q) rdata0_d = unmapped_q ? UNMAPPED_RDATA : bus.mem_rdata;
          end
        end else begin
          cnt_d     = cnt_q - ws_t'(1);
          nce_rom_d = nce_rom_q;
          nce_ram_d = nce_ram_q;
          nce_out_d = nce_out_q;
          re_d      = re_q;
          wr_d      = we_q && !unmapped_q && (cnt_q == ws_t'(1));
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = wr_q;
  assign bus.nce_rom   = nce_rom_q;
  assign bus.nce_ram   = nce_ram_q;
  assign bus.nce_out   = nce_out_q;
  assign bus.grant     = grant_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m0_ready  = ready0_q;
  assign bus.m1_ready  = ready1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter and sequencer for the shared 32-bit memory bus (ROM, RAM, output module). CPU is master 0; loader/debug port is master 1. Grants one master, decodes addr[13:11] into active-low chip enables, inserts per-region wait states, and returns read data plus a one-cycle ready pulse.

Parameters:
ROM_WS, 0, extra ACCESS cycles for region 0 (ROM)
RAM_WS, 1, extra ACCESS cycles for region 1 (RAM)
OUT_WS, 0, extra ACCESS cycles for region 2 (output module); max any WS = 15

Ports:
clk  input  1  bus clock
rst  input  1  synchronous, active-high reset
mN_req  input  1  master N (N=0,1) request; held until mN_ready
mN_we  input  1  master N write (1) / read (0)
mN_addr  input  32  master N byte address
mN_wdata  input  32  master N write data
mN_rdata  output  32  master N read data, registered, valid when mN_ready=1
mN_ready  output  1  master N one-cycle completion pulse
mN_err  output  1  master N unmapped-region flag, pulses with mN_ready
mem_addr  output  32  latched address to slaves
mem_wdata  output  32  latched write data
mem_rdata  input  32  shared slave read data
mem_re  output  1  read strobe
mem_we  output  1  write strobe
nce_rom  output  1  ROM enable, active-low
nce_ram  output  1  RAM enable, active-low
nce_out  output  1  output-module enable, active-low
grant  output  1  current/last granted master index

Behaviour:
- Reset: state=IDLE; nce_*=1; mem_re=mem_we=0; mem_addr=mem_wdata=0; mN_rdata=0; mN_ready=mN_err=0; grant=0.
- FSM IDLE -> ACCESS -> DONE -> IDLE. Registered outputs.
- IDLE: if any req, select winner, latch addr/wdata/we, set grant, decode region=addr[13:11], load wait counter with region WS; -> ACCESS. No req: stay.
- Fixed priority (default): m0 wins any simultaneous request.
- ACCESS: drive mem_addr/mem_wdata and the region's nce low; mem_re=1 for whole phase on reads; counter decrements each cycle. mem_we=1 only on final ACCESS cycle (counter==0), so exactly one write per transaction. Counter==0 -> capture mem_rdata into granted mN_rdata (reads only; writes leave rdata unchanged) -> DONE.
- Region decode: 0 ROM, 1 RAM, 2 output; 3-7 unmapped: no nce asserted, no strobes, one ACCESS cycle, rdata=32'h0, mN_err=1 in DONE.
- DONE: nce_*=1, strobes 0, mN_ready=1 for granted master only; req ignored; -> IDLE.
- Latency: req seen at edge T -> ready high in cycle T+2+WS. Back-to-back throughput: one transaction per 3+WS cycles.
- Master must drop req in cycle after ready; req still high in IDLE is a new transaction. Inputs changing after grant are ignored (latched).
- Writes to ROM: strobes issued as normal; ROM ignores; no error.
- rst mid-transaction: abort immediately to reset values; no ready pulse; no write if reset precedes final ACCESS cycle.

Optional Feature:
ARB_ROUND_ROBIN_EN defined: on simultaneous requests, winner is the master not granted last (grant register); a lone requester always wins. Undefined: fixed priority, m0 always wins; m1 can starve.

Decomposition:
Package mem_bus_pkg: state encoding (IDLE/ACCESS/DONE), region codes (REG_ROM=0, REG_RAM=1, REG_OUT=2), UNMAPPED_RDATA=32'h0, WS counter width 4.
Sub-module mem_region_decode: combinational addr[13:11] -> {nce_rom, nce_ram, nce_out, ws, unmapped}.

Test Plan:
m0 read addr 0x0000_0004, mem_rdata=0x1234_5678, ROM_WS=0 -> nce_rom low 1 cycle, m0_rdata=0x1234_5678, m0_ready at T+2, m0_err=0.
m1 write addr 0x0000_0808 data 0xCAFE_F00D, RAM_WS=1 -> nce_ram low 2 cycles, mem_we high only 2nd cycle, m1_ready at T+3.
m0 and m1 req same cycle, both reads to 0x0800 -> m0 served first, then m1; with ARB_ROUND_ROBIN_EN, second simultaneous pair serves m1 first.
m0 read addr 0x0000_1800 (region 3) -> no nce low, no strobes, m0_rdata=0, m0_err=1 with m0_ready at T+2.
rst asserted during RAM write ACCESS cycle 1 (RAM_WS=1) -> mem_we never high, all outputs at reset values next cycle, no ready.
m0 holds req 6 cycles over RAM_WS=1 read -> exactly one ready per 4-cycle transaction; inputs changed after grant not observed on mem_addr.
